// File: rtl/vb_pkg.sv
// vb_pkg: shared definitions for the vision block mode controller.
//   - default mode bus width and legal mode count
//   - bypass mode constant
//   - lock state encoding used by the lock FSM
package vb_pkg;

   localparam int MODE_W_DEF    = 3;
   localparam int NUM_MODES_DEF = 6;
   localparam int MODE_BYPASS   = 0;

   typedef enum logic [1:0] {
      NO_LOCK = 2'd0,
      LOCKING = 2'd1,
      LOCKED  = 2'd2
   } lock_st_e;

endpackage

// File: rtl/vb_geom_check.sv
// vb_geom_check: video timing edge detect and frame geometry check.
// Ports:
//   clk, rst        pixel clock, async active-high reset
//   vid_de          data enable
//   vid_vsync       vertical sync, active-high
//   first_set_i     forces the next frame to be treated as a partial first frame
//   vs_rise_o       pulse: vsync rising edge seen this cycle
//   frame_good_o    pulse with vs_rise_o: the frame that just ended had IMG_H
//                   lines of exactly IMG_W pixels and was not a first frame
module vb_geom_check #(
   parameter int IMG_W = 1280,
   parameter int IMG_H = 720
) (
   input  logic clk,
   input  logic rst,
   input  logic vid_de,
   input  logic vid_vsync,
   input  logic first_set_i,
   output logic vs_rise_o,
   output logic frame_good_o
);

   localparam logic [15:0] IMG_W_C = 16'(IMG_W);
   localparam logic [15:0] IMG_H_C = 16'(IMG_H);

   logic        de_q, vs_q;
   logic [15:0] pix_q, line_q;
   logic        bad_q, first_q;

   logic        de_fall, line_bad;
   logic [15:0] line_inc, line_eff;

   assign de_fall   = de_q & ~vid_de;
   assign vs_rise_o = ~vs_q & vid_vsync;
   assign line_bad  = de_fall & (pix_q != IMG_W_C);
   assign line_inc  = (line_q == 16'hFFFF) ? line_q : line_q + 16'd1;

   // A line ending on the vsync edge still belongs to the frame being closed.
   assign line_eff     = de_fall ? line_inc : line_q;
   assign frame_good_o = vs_rise_o & ~(bad_q | line_bad) & (line_eff == IMG_H_C) & ~first_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         de_q    <= 1'b0;
         vs_q    <= 1'b0;
         pix_q   <= '0;
         line_q  <= '0;
         bad_q   <= 1'b0;
         first_q <= 1'b1;
      end else begin
         de_q <= vid_de;
         vs_q <= vid_vsync;
         if (vs_rise_o) begin
            pix_q   <= '0;
            line_q  <= '0;
            bad_q   <= 1'b0;
            first_q <= 1'b0;
         end else begin
            if (de_fall) begin
               bad_q  <= bad_q | line_bad;
               line_q <= line_inc;
               pix_q  <= '0;
            end else if (vid_de && pix_q != 16'hFFFF) begin
               pix_q <= pix_q + 16'd1;
            end
            if (first_set_i) first_q <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/vb_mode_ctrl.sv
// vb_mode_ctrl: frame-synchronous mode controller for the vision block.
// Checks frame geometry, declares lock after LOCK_FRAMES consecutive good
// frames, accepts mode requests over valid/ready and applies them only on a
// vsync edge while locked. Mode output is forced to bypass (0) without lock.
// Optional feature macro: VB_MODE_AUTOCYCLE_EN (auto-step active mode every
// AUTO_PERIOD good locked frames when no request is pending).
// Ports:
//   clk, rst              pixel clock, async active-high reset
//   vid_de/hsync/vsync    video timing (hsync is not checked)
//   req_valid, req_mode   mode change request
//   req_ready             request slot free
//   mode                  mode driven to vb
//   locked                geometry lock
//   mode_err              one-cycle pulse on an illegal requested mode
//   frame_cnt             vsync edges seen since reset (wrapping)
module vb_mode_ctrl
   import vb_pkg::*;
#(
   parameter int IMG_W       = 1280,
   parameter int IMG_H       = 720,
   parameter int MODE_W      = MODE_W_DEF,
   parameter int NUM_MODES   = NUM_MODES_DEF,
   parameter int LOCK_FRAMES = 3,
   parameter int TIMEOUT     = 2000000,
   parameter int AUTO_PERIOD = 60
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              vid_de,
   input  logic              vid_hsync,
   input  logic              vid_vsync,
   input  logic              req_valid,
   input  logic [MODE_W-1:0] req_mode,
   output logic              req_ready,
   output logic [MODE_W-1:0] mode,
   output logic              locked,
   output logic              mode_err,
   output logic [15:0]       frame_cnt
);

   localparam int                GC_W  = $clog2(LOCK_FRAMES + 1);
   localparam int                WD_W  = $clog2(TIMEOUT + 1);
   localparam logic [GC_W-1:0]   LF_C  = GC_W'(LOCK_FRAMES);
   localparam logic [WD_W-1:0]   WD_C  = WD_W'(TIMEOUT - 1);
   localparam logic [MODE_W:0]   NM_C  = (MODE_W + 1)'(NUM_MODES);
   localparam logic [MODE_W-1:0] BYP_C = MODE_W'(MODE_BYPASS);

   lock_st_e          state_q;
   logic [GC_W-1:0]   gcnt_q;
   logic [WD_W-1:0]   wd_q;
   logic              locked_q, rdy_q, err_q, pend_q;
   logic [MODE_W-1:0] mode_q, active_q, pend_mode_q;
   logic [15:0]       fcnt_q;

   logic              vs_rise, frame_good, wd_expire, lock_nx, xfer, legal;
   logic [GC_W-1:0]   gcnt_inc;
   logic [MODE_W-1:0] active_d, pend_mode_d;
   logic              pend_d, err_d;
   logic              unused_ok;

   vb_geom_check #(.IMG_W(IMG_W), .IMG_H(IMG_H)) u_geom (
      .clk         (clk),
      .rst         (rst),
      .vid_de      (vid_de),
      .vid_vsync   (vid_vsync),
      .first_set_i (wd_expire),
      .vs_rise_o   (vs_rise),
      .frame_good_o(frame_good)
   );

   // Watchdog fires while saturated; a vsync edge on the same cycle wins so
   // the frame it opens is not marked as a first frame again.
   assign wd_expire = (wd_q == WD_C) & ~vs_rise;
   assign gcnt_inc  = gcnt_q + GC_W'(1);

   // Lock state after this edge; mirrors the FSM below, needed early for the
   // mode-apply decision and the registered mode/locked outputs.
   always_comb begin
      lock_nx = 1'b0;
      if (vs_rise)
         lock_nx = frame_good & ((state_q == LOCKED) ||
                                 (state_q == LOCKING && gcnt_inc == LF_C) ||
                                 (state_q == NO_LOCK && LOCK_FRAMES == 1));
      else
         lock_nx = (state_q == LOCKED) & ~wd_expire;
   end

   assign xfer  = req_valid & rdy_q;
   assign legal = {1'b0, req_mode} < NM_C;

`ifdef VB_MODE_AUTOCYCLE_EN
   localparam int              AP_W = $clog2(AUTO_PERIOD + 1);
   localparam logic [AP_W-1:0] AP_C = AP_W'(AUTO_PERIOD - 1);
   logic [AP_W-1:0] auto_q, auto_d;
`endif

   // Pending request is applied from the value held before this edge, so a
   // request captured on the vsync edge itself waits for the next one.
   always_comb begin
      active_d    = active_q;
      pend_d      = pend_q;
      pend_mode_d = pend_mode_q;
`ifdef VB_MODE_AUTOCYCLE_EN
      auto_d      = auto_q;
`endif
      if (vs_rise && lock_nx) begin
         if (pend_q) begin
            active_d = pend_mode_q;
            pend_d   = 1'b0;
`ifdef VB_MODE_AUTOCYCLE_EN
            auto_d   = '0;
         end else if (auto_q == AP_C) begin
            active_d = (active_q == MODE_W'(NUM_MODES - 1)) ? '0 : active_q + MODE_W'(1);
            auto_d   = '0;
         end else begin
            auto_d   = auto_q + AP_W'(1);
`endif
         end
      end
      err_d = xfer & ~legal;
      if (xfer && legal) begin
         pend_d      = 1'b1;
         pend_mode_d = req_mode;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= NO_LOCK;
         gcnt_q      <= '0;
         wd_q        <= '0;
         locked_q    <= 1'b0;
         mode_q      <= BYP_C;
         active_q    <= BYP_C;
         pend_q      <= 1'b0;
         pend_mode_q <= '0;
         rdy_q       <= 1'b1;
         err_q       <= 1'b0;
         fcnt_q      <= '0;
`ifdef VB_MODE_AUTOCYCLE_EN
         auto_q      <= '0;
`endif
      end else begin
         if (vs_rise)          wd_q <= '0;
         else if (wd_q != WD_C) wd_q <= wd_q + WD_W'(1);

         if (vs_rise) begin
            fcnt_q <= fcnt_q + 16'd1;
            case (state_q)
               NO_LOCK: if (frame_good) begin
                  if (LOCK_FRAMES == 1) state_q <= LOCKED;
                  else                  state_q <= LOCKING;
                  gcnt_q <= GC_W'(1);
               end
               LOCKING: if (frame_good) begin
                  gcnt_q <= gcnt_inc;
                  if (gcnt_inc == LF_C) state_q <= LOCKED;
               end else begin
                  state_q <= NO_LOCK;
                  gcnt_q  <= '0;
               end
               LOCKED: if (!frame_good) begin
                  state_q <= NO_LOCK;
                  gcnt_q  <= '0;
               end
               default: begin
                  state_q <= NO_LOCK;
                  gcnt_q  <= '0;
               end
            endcase
         end else if (wd_expire) begin
            state_q <= NO_LOCK;
            gcnt_q  <= '0;
         end

         locked_q    <= lock_nx;
         mode_q      <= lock_nx ? active_d : BYP_C;
         active_q    <= active_d;
         pend_q      <= pend_d;
         pend_mode_q <= pend_mode_d;
         rdy_q       <= ~pend_d;
         err_q       <= err_d;
`ifdef VB_MODE_AUTOCYCLE_EN
         auto_q      <= auto_d;
`endif
      end
   end

   assign req_ready = rdy_q;
   assign mode      = mode_q;
   assign locked    = locked_q;
   assign mode_err  = err_q;
   assign frame_cnt = fcnt_q;

`ifdef VB_MODE_AUTOCYCLE_EN
   assign unused_ok = &{1'b0, vid_hsync};
`else
   assign unused_ok = &{1'b0, vid_hsync, AUTO_PERIOD[0]};
`endif

endmodule

// File: doc/vb_mode_ctrl.md
Name: vb_mode_ctrl

Overview:
- Frame-synchronous controller for the vision block (vb) mode input.
- Monitors the incoming video timing (de/vsync) and checks frame geometry against IMG_W x IMG_H.
- Declares video lock after LOCK_FRAMES consecutive good frames.
- Accepts mode-change requests through a valid/ready handshake and applies them only at frame boundaries; forces bypass mode 0 whenever lock is absent.

Parameters:
- IMG_W, 1280, expected active pixels per line
- IMG_H, 720, expected active lines per frame
- MODE_W, 3, width of the mode bus
- NUM_MODES, 6, legal modes are 0..NUM_MODES-1
- LOCK_FRAMES, 3, consecutive good frames required for lock (>=1)
- TIMEOUT, 2000000, clk cycles without a vsync rising edge before lock is dropped
- AUTO_PERIOD, 60, frames per mode step (optional feature only)

Ports:
- clk  in  1  pixel clock
- rst  in  1  asynchronous reset, active-high
- vid_de  in  1  data enable
- vid_hsync  in  1  horizontal sync (monitored only, not checked)
- vid_vsync  in  1  vertical sync, active-high
- req_valid  in  1  mode change request
- req_mode  in  MODE_W  requested mode
- req_ready  out  1  request slot free
- mode  out  MODE_W  mode driven to vb
- locked  out  1  geometry lock
- mode_err  out  1  one-cycle pulse: illegal mode requested
- frame_cnt  out  16  frames seen since reset, wraps at 65535 -> 0

Behaviour:
- Reset values: mode=0, locked=0, req_ready=1, mode_err=0, frame_cnt=0. Internal counters, pending request, lock FSM (NO_LOCK) and first_frame=1 are also reset.
- Edge detect:
  - vid_de and vid_vsync are registered once.
  - de_fall = prev & ~cur; vs_rise = ~prev & cur.
  - Events therefore take effect one cycle after the input edge.
- Pixel and line counting:
  - pix_cnt increments on each de=1 cycle.
  - On de_fall: if pix_cnt != IMG_W then set frame_bad; line_cnt++ (saturating); pix_cnt=0.
- Frame end (vs_rise):
  - frame_good = ~frame_bad & (line_cnt==IMG_H) & ~first_frame.
  - Then clear pix_cnt, line_cnt, frame_bad, first_frame; increment frame_cnt.
  - The first partial frame after reset is always bad.
- Lock FSM (evaluated on vs_rise):
  - NO_LOCK: good -> LOCKING with good_cnt=1, or directly to LOCKED if LOCK_FRAMES==1; bad -> stay.
  - LOCKING: good -> good_cnt++; reaching LOCK_FRAMES -> LOCKED. Bad -> NO_LOCK.
  - LOCKED: bad -> NO_LOCK.
  - locked = (state==LOCKED), registered.
- Watchdog:
  - wd_cnt clears on vs_rise and otherwise increments.
  - Reaching TIMEOUT-1 -> state NO_LOCK, good_cnt=0, first_frame=1; the counter then holds.
- Request handshake:
  - Transfer occurs when req_valid & req_ready.
  - Legal mode: stored as pending; req_ready=0 from the next cycle.
  - Illegal mode (>=NUM_MODES): mode_err=1 next cycle; nothing is stored; req_ready stays 1.
- Mode application:
  - Condition: vs_rise and the lock FSM's next state is LOCKED.
  - Effect: active_mode <= pending (if any), pending cleared, req_ready=1 the following cycle.
  - Without lock, pending is held and req_ready stays 0.
- Mode output:
  - mode = locked ? active_mode : 0, registered.
  - Losing lock does not clear active_mode; it is restored when lock returns.
- Simultaneous events:
  - Request transfer on the same cycle as vs_rise: the request is captured but applied at the next vs_rise, not the current one.
  - de_fall on the same cycle as vs_rise: de_fall counts toward the ending frame.
- Reset mid-frame: everything returns to reset values immediately (asynchronous).

Optional Feature:
- Macro: VB_MODE_AUTOCYCLE_EN.
- Defined:
  - While LOCKED and no request is pending, an internal frame counter steps active_mode every AUTO_PERIOD good frames: 0,1,..,NUM_MODES-1,0.
  - A handshake request overrides the step on that vs_rise and restarts the period count.
- Undefined: the counter and step logic are absent; mode changes only through requests.

Decomposition:
- Shared package vb_pkg:
  - lock state encoding (NO_LOCK=2'd0, LOCKING=2'd1, LOCKED=2'd2)
  - MODE_W and NUM_MODES defaults
  - mode constant MODE_BYPASS=0
- One natural sub-module, vb_geom_check:
  - contains edge detect, pix/line counters, frame_bad and first_frame
  - outputs vs_rise and frame_good pulses
- The top level holds the lock FSM, watchdog, handshake and mode register.

Test Plan:
- Lock: IMG_W=8, IMG_H=4, LOCK_FRAMES=3, perfect frames -> locked=1 one cycle after the 4th vs_rise (the first frame is partial); mode=0.
- Request: while locked, req_mode=2 mid-frame -> req_ready=0 next cycle; mode=2 one cycle after next vs_rise; req_ready=1.
- Geometry error: one line of 7 pixels -> locked=0 and mode=0 after that vs_rise; 3 good frames later mode returns to 2.
- Illegal request: req_mode=7 with NUM_MODES=6 -> single mode_err pulse; req_ready stays 1; mode unchanged.
- Watchdog: TIMEOUT=100, vsync held low 100 cycles -> locked=0; the next frame counts as first_frame (bad).
- Async reset asserted mid-frame with a request pending -> all outputs at reset values within the reset window; req_ready=1; frame_cnt=0.
